counter_seq_ctrl: RTL and testbench

Command-driven sequencer for the 8-bit programmable counter (`counter_8bit`) in the Tiny Tapeout top. It accepts one command at a time over a valid/ready handshake: load a value, step N times up or down, or run to a target value. It drives the counter's `load`/`en`/`up_down`/`data_in` pins, observes `q`, and reports completion, wrap-around and abort status. It sits between the pin-decode logic and the counter, and shares `clk`/`rst_n` with it.

---
 rtl/counter_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for the 8-bit programmable counter: LOAD, STEP_UP/DOWN by N,
// or RUN_TO a target, with done/wrapped/aborted status reporting.
module counter_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic             cnt_up_down,
  output logic [WIDTH-1:0] cnt_data,
  output logic             done,
  output logic             wrapped,
  output logic             aborted
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAN = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  logic [1:0]       state_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] arg_r;
  logic [WIDTH-1:0] rem_r;
  logic             dir_r;
  logic             wrapped_r;
  logic             aborted_r;
  logic             step_wrap_s;

  // A step wraps when it moves past either end of the counter range.
  assign step_wrap_s = (dir_r && (cnt_q == CNT_MAX)) || (!dir_r && (cnt_q == CNT_ZERO));

  // Counter-side and handshake outputs decoded from the current state.
  always_comb begin
    cmd_ready   = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    cnt_up_down = 1'b0;
    cnt_data    = CNT_ZERO;
    done        = 1'b0;
    case (state_r)
      ST_IDLE: cmd_ready = 1'b1;
      ST_PLAN: begin
        if (op_r == OP_LOAD) begin
          cnt_load = 1'b1;
          cnt_data = arg_r;
        end else begin
          cnt_load = 1'b0;
          cnt_data = CNT_ZERO;
        end
      end
      ST_STEP: begin
        cnt_en      = ~abort;
        cnt_up_down = dir_r;
      end
      ST_DONE: done = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Sequencer state, latched command, step bookkeeping and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'b00;
      arg_r     <= CNT_ZERO;
      rem_r     <= CNT_ZERO;
      dir_r     <= 1'b0;
      wrapped_r <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r      <= cmd_op;
            arg_r     <= cmd_arg;
            wrapped_r <= 1'b0;
            aborted_r <= 1'b0;
            state_r   <= ST_PLAN;
          end
        end
        ST_PLAN: begin
          case (op_r)
            OP_LOAD: state_r <= ST_DONE;
            OP_UP, OP_DOWN: begin
              rem_r   <= arg_r;
              dir_r   <= (op_r == OP_UP);
              state_r <= (arg_r == CNT_ZERO) ? ST_DONE : ST_STEP;
            end
            OP_RUN: begin
              // Direct unsigned distance; RUN_TO never takes the wrap path.
              if (arg_r > cnt_q) begin
                dir_r   <= 1'b1;
                rem_r   <= arg_r - cnt_q;
                state_r <= ST_STEP;
              end else if (arg_r < cnt_q) begin
                dir_r   <= 1'b0;
                rem_r   <= cnt_q - arg_r;
                state_r <= ST_STEP;
              end else begin
                state_r <= ST_DONE;
              end
            end
            default: state_r <= ST_DONE;
          endcase
        end
        ST_STEP: begin
          if (abort) begin
            aborted_r <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            rem_r <= rem_r - CNT_ONE;
            if (step_wrap_s) begin
              wrapped_r <= 1'b1;
            end
            if (rem_r == CNT_ONE) begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign wrapped = wrapped_r;
  assign aborted = aborted_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed vector table, multi-cycle
// corner sequences, and randomized commands against a command-level model.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic [7:0] cnt_q;
  logic       cnt_load, cnt_en, cnt_up_down;
  logic [7:0] cnt_data;
  logic       done, wrapped, aborted;

  int n_tests = 0;
  int n_fail  = 0;
  int q_exp   = 0;

  counter_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .cnt_q(cnt_q),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_up_down(cnt_up_down),
    .cnt_data(cnt_data), .done(done), .wrapped(wrapped), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for counter_8bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'h00;
    else if (cnt_load) cnt_q <= cnt_data;
    else if (cnt_en) cnt_q <= cnt_up_down ? cnt_q + 8'h01 : cnt_q - 8'h01;
  end

  typedef struct {
    int op; int arg; int abort_at;
    int q; int wr; int ab; int cycles; int ens; int loads; int dir;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Command-level expectation: distance, clipped by abort, applied modulo 256.
  function automatic vec_t model(input int op, input int arg, input int abort_at, input int q);
    vec_t v;
    int n, up, steps, nq;
    v.op = op; v.arg = arg; v.abort_at = abort_at;
    if (op == 0) begin
      v.q = arg; v.wr = 0; v.ab = 0; v.cycles = 2; v.ens = 0; v.loads = 1; v.dir = 0;
      return v;
    end
    if (op == 3) begin
      up = (arg > q) ? 1 : 0;
      n  = up ? arg - q : q - arg;
    end else begin
      up = (op == 1) ? 1 : 0;
      n  = arg;
    end
    v.ab   = (abort_at != 0 && abort_at <= n) ? 1 : 0;
    steps  = v.ab ? abort_at - 1 : n;
    nq     = up ? q + steps : q - steps;
    v.wr   = (nq > 255 || nq < 0) ? 1 : 0;
    v.q    = (nq + 256) % 256;
    v.cycles = (n == 0) ? 2 : (v.ab ? abort_at + 2 : n + 2);
    v.ens  = steps; v.loads = 0; v.dir = up;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v, input string tag);
    int en_cnt = 0, load_cnt = 0, dir_err = 0, out_err = 0;
    int got_done = 0, done_k = 0, q_at = 0, wr_at = 0, ab_at = 0;
    for (int w = 0; w < 10 && !cmd_ready; w++) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op[1:0]; cmd_arg = v.arg[7:0];
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort = (v.abort_at != 0 && k == v.abort_at + 1);
      #1;
      if (cnt_en) en_cnt++;
      if (cnt_en && (cnt_up_down != v.dir[0])) dir_err++;
      if (cnt_load) load_cnt++;
      if (cnt_en && cnt_load) out_err++;
      if (!cnt_load && cnt_data != 8'h00) out_err++;
      if (cmd_ready) out_err++;
      if (done) begin
        got_done = 1; done_k = k; q_at = cnt_q; wr_at = wrapped; ab_at = aborted;
        break;
      end
    end
    check({tag, " done_seen"}, got_done, 1);
    check({tag, " done_cycle"}, done_k, v.cycles);
    check({tag, " en_cycles"}, en_cnt, v.ens);
    check({tag, " load_cycles"}, load_cnt, v.loads);
    check({tag, " dir_errors"}, dir_err, 0);
    check({tag, " output_rule_errors"}, out_err, 0);
    check({tag, " q_final"}, q_at, v.q);
    check({tag, " wrapped"}, wr_at, v.wr);
    check({tag, " aborted"}, ab_at, v.ab);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check({tag, " ready_after"}, int'(cmd_ready), 1);
    check({tag, " done_once"}, int'(done), 0);
    check({tag, " wrapped_sticky"}, int'(wrapped), v.wr);
    q_exp = v.q;
  endtask

  initial begin
    int done_mask, ready_mask, en_cnt, op, arg, ab_at;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00; abort = 1'b0;
    #1;
    check("reset outputs", {cmd_ready, cnt_load, cnt_en, cnt_up_down, done, wrapped, aborted},
          7'b1000000);
    check("reset cnt_data", int'(cnt_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //        op arg  ab  q     wr ab cyc ens ld dir
    tbl[0]  = '{0, 'h5A, 0, 'h5A, 0, 0, 2, 0, 1, 0};
    tbl[1]  = '{0, 'hFD, 0, 'hFD, 0, 0, 2, 0, 1, 0};
    tbl[2]  = '{1, 5,    0, 'h02, 1, 0, 7, 5, 0, 1};
    tbl[3]  = '{0, 'h10, 0, 'h10, 0, 0, 2, 0, 1, 0};
    tbl[4]  = '{3, 'h0C, 0, 'h0C, 0, 0, 6, 4, 0, 0};
    tbl[5]  = '{3, 'h0C, 0, 'h0C, 0, 0, 2, 0, 0, 0};
    tbl[6]  = '{0, 'h00, 0, 'h00, 0, 0, 2, 0, 1, 0};
    tbl[7]  = '{2, 0,    0, 'h00, 0, 0, 2, 0, 0, 0};
    tbl[8]  = '{1, 10,   4, 'h03, 0, 1, 6, 3, 0, 1};
    tbl[9]  = '{0, 'h01, 0, 'h01, 0, 0, 2, 0, 1, 0};
    tbl[10] = '{2, 3,    0, 'hFE, 1, 0, 5, 3, 0, 0};
    tbl[11] = '{3, 'hFF, 0, 'hFF, 0, 0, 3, 1, 0, 1};
    tbl[12] = '{1, 1,    0, 'h00, 1, 0, 3, 1, 0, 1};
    tbl[13] = '{1, 2,    3, 'h02, 0, 0, 4, 2, 0, 1};
    for (int i = 0; i < 14; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a long STEP_UP: immediate return to reset values.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd20;
    repeat (4) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midreset outputs", {cmd_ready, cnt_load, cnt_en, cnt_up_down, done, wrapped, aborted},
          7'b1000000);
    check("midreset cnt_data", int'(cnt_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_mask = 0; ready_mask = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      done_mask |= int'(done);
      ready_mask += int'(cmd_ready);
    end
    check("midreset no done", done_mask, 0);
    check("midreset ready", ready_mask, 4);
    q_exp = 0;

    // cmd_valid held high: accepted only from IDLE, throughput N+3.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd2;
    done_mask = 0; ready_mask = 0; en_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) cmd_valid = 1'b0;
      #1;
      if (done) done_mask |= (1 << k);
      if (cmd_ready) ready_mask |= (1 << k);
      if (cnt_en) en_cnt++;
    end
    check("held valid done cycles", done_mask, 'h210);
    check("held valid ready cycles", ready_mask, 'h420);
    check("held valid en count", en_cnt, 4);
    check("held valid q", int'(cnt_q), 4);
    q_exp = 4;

    // Randomized commands against the command-level model.
    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 3);
      arg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      if (op == 0 && $urandom_range(0, 1) == 1) arg = ($urandom_range(0, 1) == 1) ? 250 : 3;
      ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, arg + 1) : 0;
      run_cmd(model(op, arg, ab_at, q_exp), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
